// File: rtl/haze_pkg.sv
// haze_pkg: register map, reset saturation limits and width helper shared by the haze mixer.
package haze_pkg;
    localparam logic [15:0] A_GAIN = 16'h0100;
    localparam logic [15:0] A_STEP = 16'h0140;
    localparam logic [15:0] A_MAX  = 16'h0144;
    localparam logic [15:0] A_MIN  = 16'h0148;
    localparam logic [15:0] A_STAT = 16'h014C;
    localparam logic [15:0] A_SR   = 16'h0200;
    localparam logic [15:0] A_GB   = 16'h020C;
    localparam logic [15:0] A_NCH  = 16'h0210;
    localparam logic signed [13:0] OUT_MAX_RST = 14'sh1FFF;
    localparam logic signed [13:0] OUT_MIN_RST = 14'sh2000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/haze_gain_ramp.sv
// haze_gain_ramp: slews one current gain toward its target by at most step per cycle.
module haze_gain_ramp
    import haze_pkg::*;
#(
    parameter int GAINBITS = 24
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic signed [GAINBITS-1:0] tgt_i,
    input  logic        [GAINBITS-2:0] step_i,
    output logic signed [GAINBITS-1:0] cur_o,
    output logic                       ramp_o
);
    logic signed [GAINBITS-1:0] cur_q, cur_d;
    logic signed [GAINBITS:0]   diff, mag, stp;

    // One extra bit keeps the difference and its magnitude exact across the full gain range.
    always_comb begin
        diff  = (GAINBITS+1)'(tgt_i) - (GAINBITS+1)'(cur_q);
        mag   = diff < 0 ? -diff : diff;
        stp   = (GAINBITS+1)'(step_i);
        cur_d = (step_i == '0 || mag <= stp) ? tgt_i
              : diff < 0 ? cur_q - GAINBITS'(step_i) : cur_q + GAINBITS'(step_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cur_q <= '0;
        else         cur_q <= cur_d;
    end

    assign cur_o  = cur_q;
    assign ramp_o = cur_q != tgt_i;
endmodule

// File: rtl/red_pitaya_haze_mixer.sv
// red_pitaya_haze_mixer: NCH-channel gain-slewed mixer with 4-stage pipeline,
// programmable output clamp and a simple register bus.
module red_pitaya_haze_mixer
    import haze_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int GAINBITS = 24,
    parameter int SR       = 12
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NCH*14-1:0] dat_i,
    output logic [13:0]       dat_o,
    output logic              sat_o,
    input  logic [15:0]       addr,
    input  logic              wen,
    input  logic              ren,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata
);
    localparam int PW = 14 + GAINBITS;
    localparam int SW = PW + clog2(NCH);

    logic signed [GAINBITS-1:0] tgt_q [NCH];
    logic signed [GAINBITS-1:0] cur   [NCH];
    logic signed [GAINBITS-1:0] g_q   [NCH];
    logic signed [13:0]         x_q   [NCH];
    logic signed [PW-1:0]       p_q   [NCH];
    logic        [GAINBITS-2:0] step_q;
    logic signed [13:0]         max_q, min_q, dat_q, dat_d;
    logic signed [SW-1:0]       acc, y_q, y_d, c1, c2;
    logic [NCH-1:0]             ramp, gsel;
    logic                       sat_q, sat_d, ack_q;
    logic [31:0]                rdata_q, rdata_d;
    logic                       unused_wdata;

    assign unused_wdata = &{1'b0, wdata};

    for (genvar k = 0; k < NCH; k++) begin : g_ramp
        haze_gain_ramp #(.GAINBITS(GAINBITS)) u_ramp (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .tgt_i  (tgt_q[k]),
            .step_i (step_q),
            .cur_o  (cur[k]),
            .ramp_o (ramp[k])
        );
    end

    always_comb begin
        rdata_d = '0;
        gsel    = '0;
        for (int i = 0; i < NCH; i++) begin
            gsel[i] = addr == A_GAIN + 16'(4 * i);
            if (gsel[i]) rdata_d = 32'(tgt_q[i]);
        end
        rdata_d = addr == A_STEP ? 32'(step_q)
                : addr == A_MAX  ? 32'(max_q)
                : addr == A_MIN  ? 32'(min_q)
                : addr == A_STAT ? 32'(ramp)
                : addr == A_SR   ? 32'(SR)
                : addr == A_GB   ? 32'(GAINBITS)
                : addr == A_NCH  ? 32'(NCH)
                : rdata_d;
        acc = '0;
        for (int i = 0; i < NCH; i++) acc = acc + SW'(p_q[i]);
        y_d = acc >>> SR;
        // Max is applied first so an inverted window resolves to out_min.
        c1    = y_q > SW'(max_q) ? SW'(max_q) : y_q;
        c2    = c1 < SW'(min_q) ? SW'(min_q) : c1;
        dat_d = c2[13:0];
        sat_d = c2 != y_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tgt_q   <= '{default: '0};
            g_q     <= '{default: '0};
            x_q     <= '{default: '0};
            p_q     <= '{default: '0};
            step_q  <= '0;
            max_q   <= OUT_MAX_RST;
            min_q   <= OUT_MIN_RST;
            y_q     <= '0;
            dat_q   <= '0;
            sat_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= wen | ren;
            if (ren) rdata_q <= rdata_d;
            if (wen) begin
                for (int i = 0; i < NCH; i++) if (gsel[i]) tgt_q[i] <= wdata[GAINBITS-1:0];
                if (addr == A_STEP) step_q <= wdata[GAINBITS-2:0];
                if (addr == A_MAX)  max_q  <= wdata[13:0];
                if (addr == A_MIN)  min_q  <= wdata[13:0];
            end
            for (int i = 0; i < NCH; i++) begin
                x_q[i] <= dat_i[14*i +: 14];
                g_q[i] <= cur[i];
                p_q[i] <= PW'(x_q[i]) * PW'(g_q[i]);
            end
            y_q   <= y_d;
            dat_q <= dat_d;
            sat_q <= sat_d;
        end
    end

    assign dat_o = dat_q;
    assign sat_o = sat_q;
    assign ack   = ack_q;
    assign rdata = rdata_q;
endmodule

// File: doc/red_pitaya_haze_mixer.md
RED_PITAYA_HAZE_MIXER -- requirements
Module: red_pitaya_haze_mixer

Interface
REQ-001 SHALL have parameter NCH, default 4, number of input channels (2..8).
REQ-002 SHALL have parameter GAINBITS, default 24, signed gain width.
REQ-003 SHALL have parameter SR, default 12, gain binary-point position (product right-shift).
REQ-004 SHALL have port clk_i  input  1  the single clock.
REQ-005 SHALL have port rstn_i  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port dat_i  input  NCH*14  signed inputs; channel k occupies bits [14k+13:14k].
REQ-007 SHALL have port dat_o  output  14  saturated signed mixed output, registered.
REQ-008 SHALL have port sat_o  output  1  high while the current dat_o sample was clamped.
REQ-009 SHALL have port addr  input  16  bus address.
REQ-010 SHALL have ports wen and ren  input  1 each  bus write and read strobes.
REQ-011 SHALL have port wdata  input  32  bus write data.
REQ-012 SHALL have port ack  output  1  bus acknowledge, registered.
REQ-013 SHALL have port rdata  output  32  bus read data, registered.

Function
REQ-014 SHALL map registers: 0x100+4k target gain k (RW, GAINBITS); 0x140 slew step (RW, GAINBITS-1 bits, unsigned); 0x144 out_max (RW, 14b signed); 0x148 out_min (RW, 14b signed); 0x14C ramp status (RO, bit k = channel k ramping); 0x200 SR, 0x20C GAINBITS, 0x210 NCH (RO constants).
REQ-015 SHALL assert ack exactly one cycle after any cycle with wen|ren, for any address; unmapped reads return 0 and unmapped writes are ignored.
REQ-016 SHALL sign-extend read-back of signed fields to 32 bits.
REQ-017 SHALL update each current gain once per cycle: if step==0, cur=tgt; if |tgt-cur|<=step, cur=tgt; otherwise cur moves by step toward tgt.
REQ-018 SHALL retarget a ramp in progress from the present cur value on a new target write, with no restart or discontinuity.
REQ-019 SHALL pipeline the datapath: S1 registers inputs and cur gains; S2 registers the NCH full-width products (14+GAINBITS); S3 registers the sum (width 14+GAINBITS+clog2(NCH)) arithmetically shifted right by SR (floor); S4 registers the clamped dat_o and sat_o.
REQ-020 SHALL give a fixed latency of 4 cycles from dat_i to dat_o, independent of gains.
REQ-021 SHALL clamp the sum to out_max and then to out_min, so that out_min>out_max yields out_min; sat_o is high when either clamp changed the value.
REQ-022 SHALL apply a register write to the datapath from the cycle after the write; the new value reaches dat_o no earlier than 4 cycles later.
REQ-023 SHALL give a simultaneous wen and ren the write effect, and rdata returns the pre-write value.

Reset
REQ-024 SHALL, on rstn_i low, asynchronously clear all targets, current gains, step, and pipeline registers, and clear dat_o, sat_o, ack and rdata to 0.
REQ-025 SHALL reset out_max to 0x1FFF and out_min to 0x2000 (-8192).
REQ-026 SHALL abandon any ramp on reset assertion mid-ramp; after release, cur equals 0 with status 0.

Structure
REQ-027 SHALL place register address constants, the default saturation limits and the clog2 helper in a shared package haze_pkg.
REQ-028 SHALL implement the per-channel gain slew as one sub-module, haze_gain_ramp, instantiated NCH times.

Verification
REQ-029 SHALL cover: NCH=4, SR=12, step=0, gain0=0x1000 with the other gains 0, dat_i ch0=1000 -> dat_o=1000 exactly 4 cycles later, sat_o=0.
REQ-030 SHALL cover: all gains 0x1000, all inputs 0x1FFF -> dat_o=0x1FFF and sat_o=1; with all inputs 0x2000 -> dat_o=0x2000 and sat_o=1.
REQ-031 SHALL cover: step=0x100, gain0 written 0x1000 from 0 -> status bit0 high for 16 cycles; cur reaches 0x1000 on the 16th update; status then clears.
REQ-032 SHALL cover: mid-ramp at cur=0x800 with target changed to 0 -> cur descends 0x700, 0x600, and so on, with no jump.
REQ-033 SHALL cover: out_max=100 and out_min=-100, input 500 at unity gain -> dat_o=100 and sat_o=1; out_min=200 with out_max=100 -> dat_o=200.
REQ-034 SHALL cover: rstn_i pulsed low mid-ramp without a clock edge -> all outputs 0 immediately; reads of 0x100 return 0, of 0x144 return 0x1FFF, and of 0x148 return 0xFFFFE000.
